// File: rtl/sdram_sched_pkg.sv
// Shared types and constants for the SDRAM request scheduler and its picker.
package sdram_sched_pkg;

    // Width of each per-channel age counter.
    localparam int AGE_W = 4;
    // Width of the channel select that steers the downstream mux.
    localparam int SEL_W = 2;

    // Scheduler state encoding. Kept as plain constants so older code that
    // compares raw state values keeps working.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t BUSY  = 2'd2;

    // Channel assignment on the NeoGeo bus.
    typedef enum logic [SEL_W-1:0] {
        CH_M68K = 2'd0,
        CH_CROM = 2'd1,
        CH_SROM = 2'd2,
        CH_CDWR = 2'd3
    } ch_e;

    // Saturating age increment.
    function automatic logic [AGE_W-1:0] age_step(input logic [AGE_W-1:0] age,
                                                  input logic [AGE_W-1:0] limit);
        return (age < limit) ? age + 1'b1 : limit;
    endfunction

endpackage

// File: rtl/sdram_sched_pick.sv
// Combinational aged-priority picker: an aged channel beats plain priority,
// and the lowest index wins within each class.
module sdram_sched_pick
    import sdram_sched_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int IDX_W     = 2,
    parameter int AGE_LIMIT = 8
) (
    input  logic [NCH-1:0]       pend,
    input  logic [NCH*AGE_W-1:0] ages,
    output logic [IDX_W-1:0]     win,
    output logic                 found
);

    logic [NCH-1:0] aged;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_aged
            assign aged[gi] = pend[gi] && (ages[gi*AGE_W +: AGE_W] >= AGE_W'(AGE_LIMIT));
        end
    endgenerate

    // Scan high to low so the lowest index is written last; aged pass overrides.
    always_comb begin
        win = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pend[i]) win = IDX_W'(i);
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (aged[i]) win = IDX_W'(i);
        end
    end

    assign found = |pend;

endmodule

// File: rtl/sdram_sched.sv
// Request scheduler in front of the SDRAM address/data mux: latches client
// strobes, picks one with aging, and runs the RD/WR/READY handshake.
module sdram_sched
    import sdram_sched_pkg::*;
#(
    parameter int NCH           = 4,
    parameter int AGE_LIMIT     = 8,
    parameter int ISSUE_TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             HOLD,
    input  logic [NCH-1:0]   REQ,
    input  logic [NCH-1:0]   REQ_WR,
    input  logic [NCH-1:0]   REQ_BURST,
    input  logic             SDRAM_READY,
    input  logic [63:0]      SDRAM_DOUT,
    output logic             SDRAM_RD,
    output logic             SDRAM_WR,
    output logic             SDRAM_BURST,
    output logic [1:0]       SEL,
    output logic             SEL_VALID,
    output logic [NCH-1:0]   ACK,
    output logic [63:0]      RDATA,
    output logic [NCH-1:0]   PENDING,
    output logic [7:0]       TIMEOUT_CNT
);

    localparam int TC_W = $clog2(ISSUE_TIMEOUT + 1);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic                 burst_q, burst_d;
    logic                 cur_rd_q, cur_rd_d;
    logic [NCH-1:0]       ack_q, ack_d;
    logic [63:0]          rdata_q, rdata_d;
    logic [NCH-1:0]       pending_q, pending_d;
    logic [NCH-1:0]       type_wr_q, type_wr_d;
    logic [NCH-1:0]       type_burst_q, type_burst_d;
    logic [NCH*AGE_W-1:0] ages_q, ages_d;
    logic [TC_W-1:0]      tcnt_q, tcnt_d;
    logic [7:0]           tocnt_q, tocnt_d;

    logic [SEL_W-1:0]     pick_win;
    logic                 pick_found;
    logic                 grant;

    sdram_sched_pick #(
        .NCH       (NCH),
        .IDX_W     (SEL_W),
        .AGE_LIMIT (AGE_LIMIT)
    ) u_pick (
        .pend  (pending_q),
        .ages  (ages_q),
        .win   (pick_win),
        .found (pick_found)
    );

    // Next-state: FSM, request latch and age bookkeeping.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        burst_d      = burst_q;
        cur_rd_d     = cur_rd_q;
        ack_d        = '0;
        rdata_d      = rdata_q;
        pending_d    = pending_q;
        type_wr_d    = type_wr_q;
        type_burst_d = type_burst_q;
        ages_d       = ages_q;
        tcnt_d       = tcnt_q;
        tocnt_d      = tocnt_q;
        grant        = 1'b0;

        case (state_q)
            IDLE: begin
                // Skip the ACK cycle so the downstream mux sees one idle
                // cycle between accesses.
                if (SDRAM_READY && !HOLD && pick_found && (ack_q == '0)) begin
                    grant              = 1'b1;
                    state_d            = ISSUE;
                    sel_d              = pick_win;
                    pending_d[pick_win] = 1'b0;
                    rd_d               = !type_wr_q[pick_win];
                    wr_d               = type_wr_q[pick_win];
                    burst_d            = !type_wr_q[pick_win] && type_burst_q[pick_win];
                    cur_rd_d           = !type_wr_q[pick_win];
                    tcnt_d             = '0;
                end
            end
            ISSUE: begin
                if (!SDRAM_READY) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    burst_d = 1'b0;
                    state_d = BUSY;
                end else if (tcnt_q == TC_W'(ISSUE_TIMEOUT - 1)) begin
                    // Controller never took the command: withdraw and requeue.
                    rd_d             = 1'b0;
                    wr_d             = 1'b0;
                    burst_d          = 1'b0;
                    pending_d[sel_q] = 1'b1;
                    if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
                    state_d          = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            BUSY: begin
                if (SDRAM_READY) begin
                    if (cur_rd_q) rdata_d = SDRAM_DOUT;
                    ack_d[sel_q] = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // New strobes merge into pending and overwrite the stored type.
        pending_d = pending_d | REQ;
        for (int i = 0; i < NCH; i++) begin
            if (REQ[i]) begin
                type_wr_d[i]    = REQ_WR[i];
                type_burst_d[i] = REQ_BURST[i];
            end
        end

        // Ages move only on a grant; idle channels sit at zero.
        for (int i = 0; i < NCH; i++) begin
            if (!pending_q[i]) begin
                ages_d[i*AGE_W +: AGE_W] = '0;
            end else if (grant) begin
                if (int'(pick_win) == i)
                    ages_d[i*AGE_W +: AGE_W] = '0;
                else
                    ages_d[i*AGE_W +: AGE_W] = age_step(ages_q[i*AGE_W +: AGE_W],
                                                        AGE_W'(AGE_LIMIT));
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q      <= IDLE;
            sel_q        <= CH_M68K;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            burst_q      <= 1'b0;
            cur_rd_q     <= 1'b0;
            ack_q        <= '0;
            rdata_q      <= '0;
            pending_q    <= '0;
            type_wr_q    <= '0;
            type_burst_q <= '0;
            ages_q       <= '0;
            tcnt_q       <= '0;
            tocnt_q      <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            burst_q      <= burst_d;
            cur_rd_q     <= cur_rd_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            pending_q    <= pending_d;
            type_wr_q    <= type_wr_d;
            type_burst_q <= type_burst_d;
            ages_q       <= ages_d;
            tcnt_q       <= tcnt_d;
            tocnt_q      <= tocnt_d;
        end
    end

    assign SDRAM_RD    = rd_q;
    assign SDRAM_WR    = wr_q;
    assign SDRAM_BURST = burst_q;
    assign SEL         = sel_q;
    assign SEL_VALID   = (state_q != IDLE);
    assign ACK         = ack_q;
    assign RDATA       = rdata_q;
    assign PENDING     = pending_q;
    assign TIMEOUT_CNT = tocnt_q;

endmodule

// File: tb/tb_sdram_sched.sv
// Bench for sdram_sched: scripted scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the scheduling rules.
module tb_sdram_sched;

    localparam int NCH           = 4;
    localparam int AGE_LIMIT     = 8;
    localparam int ISSUE_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        hold = 1'b0;
    logic [3:0]  req = '0, req_wr = '0, req_burst = '0;
    logic        ready = 1'b1;
    logic [63:0] dout = '0;

    logic        SDRAM_RD, SDRAM_WR, SDRAM_BURST, SEL_VALID;
    logic [1:0]  SEL;
    logic [3:0]  ACK, PENDING;
    logic [63:0] RDATA;
    logic [7:0]  TIMEOUT_CNT;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    sdram_sched #(
        .NCH           (NCH),
        .AGE_LIMIT     (AGE_LIMIT),
        .ISSUE_TIMEOUT (ISSUE_TIMEOUT)
    ) dut (
        .CLK         (clk),
        .nRESET      (nreset),
        .HOLD        (hold),
        .REQ         (req),
        .REQ_WR      (req_wr),
        .REQ_BURST   (req_burst),
        .SDRAM_READY (ready),
        .SDRAM_DOUT  (dout),
        .SDRAM_RD    (SDRAM_RD),
        .SDRAM_WR    (SDRAM_WR),
        .SDRAM_BURST (SDRAM_BURST),
        .SEL         (SEL),
        .SEL_VALID   (SEL_VALID),
        .ACK         (ACK),
        .RDATA       (RDATA),
        .PENDING     (PENDING),
        .TIMEOUT_CNT (TIMEOUT_CNT)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = no access, 1 = command on the bus, 2 = waiting for READY.
    bit          m_pend[NCH];
    bit          m_fwr[NCH];
    bit          m_fburst[NCH];
    int          m_age[NCH];
    bit          m_nxt[NCH];
    int          m_phase = 0;
    int          m_sel = 0;
    bit          m_isrd = 0;
    bit          m_burstf = 0;
    int          m_cmd_age = 0;
    bit          m_ack_any = 0;
    int          m_ack_ch = 0;
    logic [63:0] m_rdata = '0;
    int          m_to = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (!nreset) begin
                for (int i = 0; i < NCH; i++) begin
                    m_pend[i] = 0; m_fwr[i] = 0; m_fburst[i] = 0; m_age[i] = 0;
                end
                m_phase = 0; m_sel = 0; m_isrd = 0; m_burstf = 0; m_cmd_age = 0;
                m_ack_any = 0; m_ack_ch = 0; m_rdata = '0; m_to = 0;
            end else begin
                bit new_ack;
                int new_ch;
                bit any;
                int w;
                new_ack = 0; new_ch = 0; any = 0;
                for (int i = 0; i < NCH; i++) begin
                    m_nxt[i] = m_pend[i];
                    any |= m_pend[i];
                end
                if (m_phase == 0 && ready && !hold && !m_ack_any && any) begin
                    w = -1;
                    for (int i = 0; i < NCH; i++)
                        if (w < 0 && m_pend[i] && m_age[i] >= AGE_LIMIT) w = i;
                    for (int i = 0; i < NCH; i++)
                        if (w < 0 && m_pend[i]) w = i;
                    for (int i = 0; i < NCH; i++) begin
                        if (!m_pend[i] || i == w) m_age[i] = 0;
                        else m_age[i] = (m_age[i] + 1 > AGE_LIMIT) ? AGE_LIMIT : m_age[i] + 1;
                    end
                    m_nxt[w] = 0;
                    m_sel = w; m_isrd = !m_fwr[w]; m_burstf = m_fburst[w];
                    m_cmd_age = 0; m_phase = 1;
                end else begin
                    for (int i = 0; i < NCH; i++) if (!m_pend[i]) m_age[i] = 0;
                    if (m_phase == 1) begin
                        if (!ready) m_phase = 2;
                        else begin
                            m_cmd_age++;
                            if (m_cmd_age == ISSUE_TIMEOUT) begin
                                m_phase = 0;
                                m_nxt[m_sel] = 1;
                                if (m_to < 255) m_to++;
                            end
                        end
                    end else if (m_phase == 2 && ready) begin
                        new_ack = 1; new_ch = m_sel;
                        if (m_isrd) m_rdata = dout;
                        m_phase = 0;
                    end
                end
                m_ack_any = new_ack; m_ack_ch = new_ch;
                for (int i = 0; i < NCH; i++) begin
                    if (req[i]) begin
                        m_nxt[i] = 1; m_fwr[i] = req_wr[i]; m_fburst[i] = req_burst[i];
                    end
                    m_pend[i] = m_nxt[i];
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            logic [3:0] e_ack, e_pend;
            @(negedge clk);
            if (cmp_en) begin
                e_ack  = m_ack_any ? (4'b0001 << m_ack_ch) : 4'b0000;
                e_pend = {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
                chk("m_rd",    SDRAM_RD,    (m_phase == 1) && m_isrd);
                chk("m_wr",    SDRAM_WR,    (m_phase == 1) && !m_isrd);
                chk("m_burst", SDRAM_BURST, (m_phase == 1) && m_isrd && m_burstf);
                chk("m_sel",   SEL,         m_sel);
                chk("m_selv",  SEL_VALID,   m_phase != 0);
                chk("m_ack",   ACK,         e_ack);
                chk("m_rdata", RDATA,       m_rdata);
                chk("m_pend",  PENDING,     e_pend);
                chk("m_tocnt", TIMEOUT_CNT, m_to);
                if (ACK != 0) $display("txn: ack=%b sel=%0d rdata=%h t=%0t", ACK, SEL, RDATA, $time);
            end
        end
    end

    // ---------------- SDRAM controller stand-in ----------------
    int          ctl_delay = 0, ctl_busy = 1;
    logic [63:0] ctl_data = '0;
    bit          ctl_rand = 0, ctl_never = 0;

    initial begin
        int cs, cd, cb;
        logic [63:0] cdat;
        cs = 0; cd = 0; cb = 1; cdat = '0;
        forever begin
            @(negedge clk);
            case (cs)
                0: if ((SDRAM_RD || SDRAM_WR) && !ctl_never) begin
                    if (ctl_rand) begin
                        cd = $urandom_range(0, 3);
                        if ($urandom_range(0, 19) == 0) cd = 20;
                        cb = $urandom_range(1, 6);
                        cdat = {$urandom, $urandom};
                    end else begin
                        cd = ctl_delay; cb = ctl_busy; cdat = ctl_data;
                    end
                    if (cd == 0) begin ready = 1'b0; cs = 2; end
                    else cs = 1;
                end
                1: begin
                    cd--;
                    if (cd == 0) begin ready = 1'b0; cs = 2; end
                end
                default: begin
                    cb--;
                    if (cb <= 0) begin ready = 1'b1; dout = cdat; cs = 0; end
                end
            endcase
        end
    end

    // Wait for the next completion, tallying the command cycles seen meanwhile.
    task automatic wait_txn(output int ch, output int rc, output int wc,
                            output int bc, output int ov);
        int got;
        ch = -1; rc = 0; wc = 0; bc = 0; ov = 0; got = 0;
        for (int k = 0; k < 200 && got == 0; k++) begin
            @(negedge clk);
            if (SDRAM_RD) rc++;
            if (SDRAM_WR) wc++;
            if (SDRAM_BURST) bc++;
            if (SDRAM_RD && SDRAM_WR) ov++;
            if (ACK != 0) begin
                got = 1;
                for (int i = 0; i < NCH; i++) if (ACK[i]) ch = i;
            end
        end
        chk("txn_done", got, 1);
    endtask

    task automatic wait_busy();
        int got;
        got = 0;
        for (int k = 0; k < 60 && got == 0; k++) begin
            @(negedge clk);
            if (SEL_VALID && !SDRAM_RD && !SDRAM_WR) got = 1;
        end
        chk("busy_seen", got, 1);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int ch, rc, wc, bc, ov, n0, done, acks;

        // Reset state
        nreset = 1'b0;
        tick(); tick();
        chk("rst_rd", SDRAM_RD, 0);
        chk("rst_selv", SEL_VALID, 0);
        chk("rst_ack", ACK, 0);
        chk("rst_pend", PENDING, 0);
        chk("rst_tocnt", TIMEOUT_CNT, 0);
        cmp_en = 1'b1;
        nreset = 1'b1;
        tick();

        // Single read on channel 2
        ctl_delay = 1; ctl_busy = 5; ctl_data = 64'h1234;
        req = 4'b0100; req_wr = 0; req_burst = 0; tick(); req = 0;
        wait_txn(ch, rc, wc, bc, ov);
        chk("read_ch", ch, 2);
        chk("read_rd_cycles", rc, 2);
        chk("read_ack", ACK, 4'b0100);
        chk("read_sel", SEL, 2);
        chk("read_rdata", RDATA, 64'h1234);

        // Priority: channel 0 read before channel 3 write
        ctl_delay = 0; ctl_busy = 2; ctl_data = 64'hA5A5;
        req = 4'b1001; req_wr = 4'b1000; req_burst = 4'b1001; tick();
        req = 0; req_wr = 0; req_burst = 0;
        wait_txn(ch, rc, wc, bc, ov);
        chk("prio_first_ch", ch, 0);
        chk("prio_first_rd", rc, 1);
        chk("prio_first_burst", bc, 1);
        chk("prio_first_wr", wc, 0);
        wait_txn(ch, rc, wc, bc, ov);
        chk("prio_second_ch", ch, 3);
        chk("prio_second_wr", wc, 1);
        chk("prio_second_rd", rc, 0);
        chk("prio_second_burst", bc, 0);
        chk("prio_overlap", ov, 0);

        // Starvation: channel 1 must win after AGE_LIMIT channel-0 grants
        ctl_delay = 0; ctl_busy = 1; ctl_data = 64'h77;
        req = 4'b0011; tick(); req = 0;
        n0 = 0; done = 0; ch = -1;
        for (int k = 0; k < 20 && done == 0; k++) begin
            wait_txn(ch, rc, wc, bc, ov);
            if (ch == 0) begin
                n0++;
                req = 4'b0001; tick(); req = 0;
            end else done = 1;
        end
        chk("starve_ch", ch, 1);
        chk("starve_grants", n0, 8);
        wait_txn(ch, rc, wc, bc, ov);
        chk("starve_drain_ch", ch, 0);

        // Timeout: controller never answers channel 1
        ctl_never = 1; ctl_delay = 0; ctl_busy = 2; ctl_data = 64'h5151;
        req = 4'b0010; req_burst = 4'b0010; tick(); req = 0; req_burst = 0;
        rc = 0; acks = 0;
        for (int k = 0; k < 100 && TIMEOUT_CNT == 0; k++) begin
            tick();
            if (SDRAM_RD) rc++;
            if (ACK != 0) acks++;
        end
        chk("to_rd_cycles", rc, 16);
        chk("to_no_ack", acks, 0);
        chk("to_pending", PENDING[1], 1);
        chk("to_cnt", TIMEOUT_CNT, 1);
        ctl_never = 0;
        wait_txn(ch, rc, wc, bc, ov);
        chk("to_retry_ch", ch, 1);
        chk("to_retry_rdata", RDATA, 64'h5151);

        // HOLD blocks grants, then does not abort a busy access
        ctl_delay = 2; ctl_busy = 3; ctl_data = 64'hBEEF;
        hold = 1; req = 4'b0010; tick(); req = 0;
        rc = 0;
        repeat (5) begin tick(); if (SDRAM_RD || SDRAM_WR) rc++; end
        chk("hold_no_cmd", rc, 0);
        chk("hold_pending", PENDING, 4'b0010);
        hold = 0; tick();
        chk("hold_release_rd", SDRAM_RD, 1);
        chk("hold_release_sel", SEL, 1);
        wait_busy();
        hold = 1;
        wait_txn(ch, rc, wc, bc, ov);
        chk("hold_busy_ack_ch", ch, 1);
        chk("hold_busy_rdata", RDATA, 64'hBEEF);
        hold = 0;

        // Reset in the middle of an access
        ctl_delay = 0; ctl_busy = 10; ctl_data = 64'hDEAD;
        req = 4'b0100; tick(); req = 0;
        wait_busy();
        nreset = 0; tick();
        chk("mrst_rd", SDRAM_RD, 0);
        chk("mrst_wr", SDRAM_WR, 0);
        chk("mrst_selv", SEL_VALID, 0);
        chk("mrst_sel", SEL, 0);
        chk("mrst_pend", PENDING, 0);
        chk("mrst_tocnt", TIMEOUT_CNT, 0);
        chk("mrst_rdata", RDATA, 0);
        nreset = 1;
        acks = 0;
        repeat (20) begin tick(); if (ACK != 0) acks++; end
        chk("mrst_no_ack", acks, 0);

        // Random traffic against the model
        ctl_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            req       = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            req_wr    = 4'($urandom);
            req_burst = 4'($urandom);
            if ($urandom_range(0, 24) == 0) hold = ~hold;
            nreset    = ($urandom_range(0, 599) != 0);
        end
        tick();
        req = 0; hold = 0; nreset = 1;
        repeat (150) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
